data_mem_ctrl: RTL

// - MEM-stage data-memory responder: serves load/store requests from EX_MEM, drives Read_Data into MEM_WB.
// - Owns word-organised on-chip data RAM; byte/half/word access with sign/zero extension.
// - Programmable wait states; stall_o holds the pipeline until the response cycle.
// - Flags misaligned/illegal accesses instead of performing them.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lane_align.sv | 65 ++++++
 rtl/data_mem_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory controller:
// RV32I load/store width codes, FSM state encoding and wait-counter width.
package dmem_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data RAM: load extract/extend, store byte enables
// with replicated write data, and legality check of the width/alignment combination.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_data,
    output logic [3:0]  o_byte_en,
    output logic        o_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_load_data  = '0;
        o_store_data = i_wdata;
        o_byte_en    = '0;
        o_err        = 1'b0;
        case (i_funct3)
            F3_LB: begin
                o_load_data  = {{24{w_byte[7]}}, w_byte};
                o_store_data = {4{i_wdata[7:0]}};
                o_byte_en    = 4'b0001 << i_addr_lo;
            end
            F3_LH: begin
                o_load_data  = {{16{w_half[15]}}, w_half};
                o_store_data = {2{i_wdata[15:0]}};
                o_byte_en    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_err        = i_addr_lo[0];
            end
            F3_LW: begin
                o_load_data  = i_rdata;
                o_byte_en    = 4'b1111;
                o_err        = |i_addr_lo;
            end
            F3_LBU: begin
                o_load_data  = {24'h0, w_byte};
                o_err        = i_wr;
            end
            F3_LHU: begin
                o_load_data  = {16'h0, w_half};
                o_err        = i_wr | i_addr_lo[0];
            end
            default: o_err = 1'b1;
        endcase
        if (i_rd && i_wr) begin
            o_err = 1'b1;
        end
        // A rejected access must never touch the RAM.
        if (o_err) begin
            o_byte_en = '0;
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory responder: word-organised RAM with byte/half/word access,
// programmable wait states, pipeline stall and misaligned-access rejection.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic        stall_o,
    output logic [31:0] Read_Data,
    output logic        rsp_valid,
    output logic        misalign_err
);

    state_t              r_state;
    logic [WAIT_W-1:0]   r_cnt;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [2:0]          r_funct3;
    logic                r_rd;
    logic                r_wr;
    logic [31:0]         r_mem [2**ADDR_W];

    logic                w_idle;
    logic                w_accept;
    logic                w_enter_resp;
    logic [31:0]         w_cur_addr;
    logic [31:0]         w_cur_wdata;
    logic [2:0]          w_cur_funct3;
    logic                w_cur_rd;
    logic                w_cur_wr;
    logic [ADDR_W-1:0]   w_idx;
    logic [31:0]         w_rdata;
    logic [31:0]         w_load_data;
    logic [31:0]         w_store_data;
    logic [3:0]          w_byte_en;
    logic                w_err;
    logic                w_unused_addr;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle && req_valid && (mem_read || mem_write);
    assign stall_o  = w_accept || (r_state == WAIT);

    // With zero wait states the access happens on the acceptance edge, so the
    // live request is used instead of the (not yet loaded) latch.
    assign w_cur_addr   = w_idle ? addr      : r_addr;
    assign w_cur_wdata  = w_idle ? wdata     : r_wdata;
    assign w_cur_funct3 = w_idle ? funct3    : r_funct3;
    assign w_cur_rd     = w_idle ? mem_read  : r_rd;
    assign w_cur_wr     = w_idle ? mem_write : r_wr;

    assign w_enter_resp = (w_accept && (WAIT_STATES == 0)) ||
                          ((r_state == WAIT) && (r_cnt == WAIT_W'(1)));

    assign w_idx         = w_cur_addr[ADDR_W+1:2];
    assign w_rdata       = r_mem[w_idx];
    assign w_unused_addr = ^w_cur_addr[31:ADDR_W+2];

    dmem_lane_align u_lane (
        .i_funct3     (w_cur_funct3),
        .i_rd         (w_cur_rd),
        .i_wr         (w_cur_wr),
        .i_addr_lo    (w_cur_addr[1:0]),
        .i_rdata      (w_rdata),
        .i_wdata      (w_cur_wdata),
        .o_load_data  (w_load_data),
        .o_store_data (w_store_data),
        .o_byte_en    (w_byte_en),
        .o_err        (w_err)
    );

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr   <= addr;
            r_wdata  <= wdata;
            r_funct3 <= funct3;
            r_rd     <= mem_read;
            r_wr     <= mem_write;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            Read_Data    <= '0;
            rsp_valid    <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            rsp_valid    <= 1'b0;
            misalign_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= WAIT_W'(WAIT_STATES);
                        r_state <= (WAIT_STATES > 0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - WAIT_W'(1);
                    if (r_cnt == WAIT_W'(1)) begin
                        r_state <= RESP;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (w_enter_resp) begin
                rsp_valid    <= 1'b1;
                misalign_err <= w_err;
                if (w_err) begin
                    Read_Data <= '0;
                end else if (w_cur_rd) begin
                    Read_Data <= w_load_data;
                end
            end
        end
    end

    // Gating on rst_n drops a store whose response edge coincides with reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_enter_resp && w_cur_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byte_en[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_store_data[8*b +: 8];
                end
            end
        end
    end

endmodule
